// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready in and out.
// Ports: clk, rst_n (async low), flush (sync abort),
//   in_valid/in_ready + op/d1/d2 request side,
//   out_valid/out_ready + res result side.
module alu_muldiv_iter #(
  parameter int BW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [BW-1:0] d1,
  input  logic [BW-1:0] d2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] res
);

  localparam int CW = $clog2(BW+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [2:0]    r_op;
  logic [CW-1:0] r_cnt;
  logic [BW:0]   r_hi;
  logic [BW-1:0] r_lo;
  logic [BW:0]   r_b;
  logic          r_neg;
  logic          r_dsign;
  logic [BW-1:0] r_res;
  logic          r_in_ready;
  logic          r_out_valid;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res       = r_res;

  logic          w_sop1;
  logic          w_sop2;
  logic          w_s1;
  logic          w_s2;
  logic [BW-1:0] w_m1;
  logic [BW-1:0] w_m2;
  logic          w_div;
  logic          w_dz;
  logic          w_ovf;
  logic [BW-1:0] w_spec;

  always_comb begin
    w_sop1 = 1'b0;
    w_sop2 = 1'b0;
    unique case (op)
      3'b001: begin w_sop1 = 1'b1; w_sop2 = 1'b1; end
      3'b010: w_sop1 = 1'b1;
      3'b100: begin w_sop1 = 1'b1; w_sop2 = 1'b1; end
      3'b110: begin w_sop1 = 1'b1; w_sop2 = 1'b1; end
      default: ;
    endcase
  end

  assign w_s1  = w_sop1 & d1[BW-1];
  assign w_s2  = w_sop2 & d2[BW-1];
  assign w_m1  = w_s1 ? (BW'(0) - d1) : d1;
  assign w_m2  = w_s2 ? (BW'(0) - d2) : d2;
  assign w_div = op[2];
  assign w_dz  = w_div & (d2 == '0);
  // Signed DIV/REM of most-negative by -1.
  assign w_ovf = w_div & ~op[0] & (&d2)
               & (d1 == {1'b1, {(BW-1){1'b0}}});

  always_comb begin
    w_spec = '0;
    unique case (1'b1)
      w_dz:    w_spec = op[1] ? d1 : '1;
      default: w_spec = op[1] ? '0 : d1;
    endcase
  end

  // One iteration step, shared register pair {r_hi, r_lo}.
  logic [BW:0]   w_add;
  logic [BW:0]   w_sh;
  logic [BW+1:0] w_diff;
  logic [BW:0]   w_hi_nxt;
  logic [BW-1:0] w_lo_nxt;

  assign w_add  = r_hi + (r_lo[0] ? r_b : '0);
  assign w_sh   = {r_hi[BW-1:0], r_lo[BW-1]};
  assign w_diff = {1'b0, w_sh} - {1'b0, r_b};

  always_comb begin
    w_hi_nxt = '0;
    w_lo_nxt = '0;
    if (r_op[2]) begin
      if (!w_diff[BW+1]) begin
        w_hi_nxt = w_diff[BW:0];
        w_lo_nxt = {r_lo[BW-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_sh;
        w_lo_nxt = {r_lo[BW-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = {1'b0, w_add[BW:1]};
      w_lo_nxt = {w_add[0], r_lo[BW-1:1]};
    end
  end

  // Sign correction folded into the final step.
  logic [2*BW-1:0] w_prod;
  logic [2*BW-1:0] w_prod_c;
  logic [BW-1:0]   w_quot_c;
  logic [BW-1:0]   w_rem;
  logic [BW-1:0]   w_rem_c;
  logic [BW-1:0]   w_fin;
  logic            w_unused_hi;

  assign w_unused_hi = w_hi_nxt[BW];
  assign w_prod   = {w_hi_nxt[BW-1:0], w_lo_nxt};
  assign w_prod_c = r_neg ? ((2*BW)'(0) - w_prod) : w_prod;
  assign w_quot_c = r_neg ? (BW'(0) - w_lo_nxt) : w_lo_nxt;
  assign w_rem    = w_hi_nxt[BW-1:0];
  assign w_rem_c  = r_dsign ? (BW'(0) - w_rem) : w_rem;

  always_comb begin
    w_fin = '0;
    unique case (r_op)
      3'b000: w_fin = w_prod_c[BW-1:0];
      3'b001: w_fin = w_prod_c[2*BW-1:BW];
      3'b010: w_fin = w_prod_c[2*BW-1:BW];
      3'b011: w_fin = w_prod_c[2*BW-1:BW];
      3'b100: w_fin = w_quot_c;
      3'b101: w_fin = w_quot_c;
      default: w_fin = w_rem_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_neg       <= 1'b0;
      r_dsign     <= 1'b0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op       <= op;
            r_neg      <= w_s1 ^ w_s2;
            r_dsign    <= w_s1;
            r_in_ready <= 1'b0;
            if (w_dz || w_ovf) begin
              r_res       <= w_spec;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_div ? w_m1 : w_m2;
              r_b     <= {1'b0, w_div ? w_m2 : w_m1};
              r_cnt   <= CW'(BW);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res       <= w_fin;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_iter.md
Name: alu_muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit: next-generation companion to the single-cycle ALU, implementing the RV32M operations over BW-bit operands.
- Sits in the EX stage beside the ALU. Decoded funct3 plus operands enter through a valid/ready handshake; the result returns through a second valid/ready handshake.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle. Divide-by-zero and signed-overflow cases are resolved in a single cycle.

Parameters:
- BW, 32, operand/result width; legal range 8..64, even.
- CW, $clog2(BW+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight operation (pipeline redirect).
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- d1  input  BW  rs1 operand (multiplicand / dividend).
- d2  input  BW  rs2 operand (multiplier / divisor).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- res  output  BW  result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, res=0, counter=0.
  - All internal registers clear.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch op and operands.
  - Compute operand magnitudes and signs:
    - Signed operands: MULH d1,d2; MULHSU d1 only; DIV/REM d1,d2.
    - Unsigned operands: MUL, MULHU, DIVU, REMU.
  - Special case at acceptance, going directly to DONE:
    - d2==0 on a divide op: DIV/DIVU return all-ones; REM/REMU return d1.
    - Signed overflow, DIV/REM with d1=100..0 and d2=all-ones: DIV returns d1; REM returns 0.
  - Otherwise go to CALC with counter=BW.
- CALC:
  - in_ready=0.
  - Each cycle performs one step and decrements the counter; after the step with counter==1, go to DONE.
  - Multiply step: if the multiplier LSB is set, add the multiplicand to the upper half of the 2BW accumulator; then shift right 1, carry kept.
  - Divide step: shift {rem,quot} left 1; trial-subtract the divisor magnitude from rem; if non-negative, keep the difference and set quot LSB.
  - Final sign correction is applied on the DONE entry edge:
    - Product is negated if the signs differ.
    - Quotient is negated if the signs differ (DIV).
    - Remainder takes the dividend sign (REM).
  - res selects the low BW bits for MUL, the high BW bits for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, and the remainder for REM/REMU.
- DONE:
  - out_valid=1, res stable, in_ready=0.
  - On out_ready, return to IDLE; out_valid drops next edge.
  - Back-pressure holds DONE indefinitely with res unchanged.
- Latency, counted from the acceptance edge:
  - Normal ops: out_valid high after BW+1 edges (BW CALC cycles plus the correction edge).
  - Special cases: out_valid high after 1 edge.
- No new request is accepted in the same cycle as out_ready; the unit is non-pipelined, with a minimum initiation interval of BW+2.
- Flush:
  - In any state, flush=1 forces IDLE on the next edge with out_valid=0; no result is delivered.
  - Flush has priority over acceptance and over out_ready.
  - in_ready is 1 in the cycle after flush.
- Reset asserted mid-CALC or in DONE: immediate IDLE and reset values; the partial result is discarded.
- All arithmetic on magnitudes is BW+1 bits wide to hold |most-negative| without overflow.
- Undefined op is impossible: all 8 encodings are legal.

Test Plan:
- BW=32, MUL d1=7, d2=-3 (0xFFFFFFFD), out_ready=1 -> res=0xFFFFFFEB; out_valid exactly 33 edges after acceptance, for one cycle.
- MULH 0x80000000 x 0x80000000 -> res=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> res=0xFFFFFFFE. MULHSU -1 x 0xFFFFFFFF -> res=0xFFFFFFFF.
- DIV -7 / 2 -> res=0xFFFFFFFD (-3). REM -7 / 2 -> res=0xFFFFFFFF (-1). DIVU 100 / 7 -> res=14. REMU 100 / 7 -> res=2.
- DIV 5 / 0 -> res=0xFFFFFFFF; REM 5 / 0 -> res=5; DIV 0x80000000 / -1 -> res=0x80000000; REM same operands -> res=0. Each has out_valid 1 edge after acceptance.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and res stable, in_valid ignored (in_ready=0); raise out_ready -> IDLE next edge.
- Flush at CALC cycle 12 -> out_valid never rises and in_ready=1 next cycle; a new MUL 3x4 completes with res=12. Separately, rst_n low mid-CALC -> outputs return to reset values asynchronously.
